stack_unit: RTL

STACK_UNIT -- requirements
Module: stack_unit

---
 rtl/stack_unit_if.sv | 29 ++
 rtl/stack_unit.sv | 119 +++++++++++
 2 files changed

// File: rtl/stack_unit_if.sv
// Control-side bundle for stack_unit: push/pop requests in, popped data and status out.
interface stack_unit_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             StackWrite;
  logic             StackRead;
  logic [WIDTH-1:0] Datain;
  logic             ClearErr;
  logic [WIDTH-1:0] Dataout;
  logic             DataValid;
  logic             Empty;
  logic             Full;
  logic [CW-1:0]    Count;
  logic             Overflow;
  logic             Underflow;

  modport master (
    output StackWrite, StackRead, Datain, ClearErr,
    input  Dataout, DataValid, Empty, Full, Count, Overflow, Underflow
  );

  modport slave (
    input  StackWrite, StackRead, Datain, ClearErr,
    output Dataout, DataValid, Empty, Full, Count, Overflow, Underflow
  );
endinterface

// File: rtl/stack_unit.sv
// LIFO stack with registered pop output, same-cycle swap, and sticky
// overflow/underflow flags enabled by the STACK_ERR_FLAG_EN macro.
module stack_unit #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         Reset,
  stack_unit_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];

  logic [CW-1:0]    sp_q, sp_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dvalid_q, dvalid_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  logic             empty, full;
  logic [AW-1:0]    top_addr;
  logic             mem_we;
  logic [AW-1:0]    mem_waddr;
  logic             ovf_ev, unf_ev;

  assign empty    = (sp_q == '0);
  assign full     = (sp_q == CW'(DEPTH));
  assign top_addr = AW'(sp_q - CW'(1));

  always_comb begin
    sp_d      = sp_q;
    dout_d    = dout_q;
    dvalid_d  = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = sp_q[AW-1:0];
    ovf_ev    = 1'b0;
    unf_ev    = 1'b0;
    case ({bus.StackWrite, bus.StackRead})
      2'b10: begin
        if (full) begin
          ovf_ev = 1'b1;
        end else begin
          mem_we = 1'b1;
          sp_d   = sp_q + CW'(1);
        end
      end
      2'b01: begin
        if (empty) begin
          unf_ev = 1'b1;
        end else begin
          dout_d   = mem[top_addr];
          dvalid_d = 1'b1;
          sp_d     = sp_q - CW'(1);
        end
      end
      2'b11: begin
        // Empty stack has nothing to swap out: degrade to a plain push.
        if (empty) begin
          mem_we = 1'b1;
          sp_d   = sp_q + CW'(1);
          unf_ev = 1'b1;
        end else begin
          dout_d    = mem[top_addr];
          dvalid_d  = 1'b1;
          mem_we    = 1'b1;
          mem_waddr = top_addr;
        end
      end
      default: ;
    endcase
  end

`ifdef STACK_ERR_FLAG_EN
  // A new error in the same cycle as ClearErr wins so no event is lost.
  always_comb begin
    ovf_d = (ovf_q & ~bus.ClearErr) | ovf_ev;
    unf_d = (unf_q & ~bus.ClearErr) | unf_ev;
  end
`else
  logic unused_err;
  assign unused_err = ovf_ev | unf_ev | bus.ClearErr;
  always_comb begin
    ovf_d = 1'b0;
    unf_d = 1'b0;
  end
`endif

  always_ff @(posedge clk) begin
    if (Reset) begin
      sp_q     <= '0;
      dout_q   <= '0;
      dvalid_q <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      sp_q     <= sp_d;
      dout_q   <= dout_d;
      dvalid_q <= dvalid_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we && !Reset) begin
      mem[mem_waddr] <= bus.Datain;
    end
  end

  assign bus.Dataout   = dout_q;
  assign bus.DataValid = dvalid_q;
  assign bus.Empty     = empty;
  assign bus.Full      = full;
  assign bus.Count     = sp_q;
  assign bus.Overflow  = ovf_q;
  assign bus.Underflow = unf_q;
endmodule
